// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ready channel between the fetch controller and imem.
// The master drives the request and address; the slave returns ready and read data.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and drives the imem handshake.
// It applies jump/exception redirects and parks one fetched word while decode stalls.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic [31:0] i_c,
    input  logic        i_e_raised,
    input  logic [31:0] i_e_handling_addr,
    fetch_ctrl_if.master imem,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc4,
    output logic [31:0] o_if_inst
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_pend_pc, w_pend_pc_next;
    logic [31:0] r_buf, w_buf_next;
    logic [31:0] r_buf_pc, w_buf_pc_next;
    logic        r_if_valid, w_if_valid_next;
    logic [31:0] r_if_pc, w_if_pc_next;
    logic [31:0] r_if_inst, w_if_inst_next;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_load_fetch;
    logic        w_load_buf;

    assign w_redir  = i_jump | i_e_raised;
    assign w_target = i_jump ? i_c : i_e_handling_addr;
    assign w_accept = !r_if_valid || !i_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'h0;
            r_buf      <= 32'h0;
            r_buf_pc   <= 32'h0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0;
            r_if_inst  <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pend_pc  <= w_pend_pc_next;
            r_buf      <= w_buf_next;
            r_buf_pc   <= w_buf_pc_next;
            r_if_valid <= w_if_valid_next;
            r_if_pc    <= w_if_pc_next;
            r_if_inst  <= w_if_inst_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_pend_pc_next  = r_pend_pc;
        w_buf_next      = r_buf;
        w_buf_pc_next   = r_buf_pc;
        w_if_valid_next = r_if_valid;
        w_if_pc_next    = r_if_pc;
        w_if_inst_next  = r_if_inst;
        w_load_fetch    = 1'b0;
        w_load_buf      = 1'b0;
        imem.imem_req   = 1'b0;
        imem.imem_addr  = r_pc;

        unique case (r_state)
            IDLE: begin
                w_state_next = REQ;
                if (w_redir) w_pc_next = w_target;
            end
            REQ: begin
                imem.imem_req = 1'b1;
                if (w_redir) begin
                    // A redirect that cannot complete this cycle must wait out the old request.
                    if (imem.imem_ready) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pend_pc_next = w_target;
                        w_state_next   = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    w_pc_next = r_pc + 32'd4;
                    if (w_accept) begin
                        w_load_fetch = 1'b1;
                    end else begin
                        w_buf_next    = imem.imem_rdata;
                        w_buf_pc_next = r_pc;
                        w_state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_redir) begin
                    w_pc_next    = w_target;
                    w_state_next = REQ;
                end else if (!i_stall) begin
                    w_load_buf   = 1'b1;
                    w_state_next = REQ;
                end
            end
            DRAIN: begin
                imem.imem_req = 1'b1;
                if (w_redir) w_pend_pc_next = w_target;
                if (imem.imem_ready) begin
                    w_pc_next    = w_redir ? w_target : r_pend_pc;
                    w_state_next = REQ;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Flush outranks both a fresh load and a decode stall.
        if (w_redir) begin
            w_if_valid_next = 1'b0;
        end else if (w_load_fetch) begin
            w_if_valid_next = 1'b1;
            w_if_pc_next    = r_pc;
            w_if_inst_next  = imem.imem_rdata;
        end else if (w_load_buf) begin
            w_if_valid_next = 1'b1;
            w_if_pc_next    = r_buf_pc;
            w_if_inst_next  = r_buf;
        end else if (!i_stall) begin
            w_if_valid_next = 1'b0;
        end
    end

    assign o_if_valid = r_if_valid;
    assign o_if_pc    = r_if_pc;
    assign o_if_pc4   = r_if_pc + 32'd4;
    assign o_if_inst  = r_if_inst;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// against a flag-based reference model of the fetch stream.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        stall, jump, e_raised;
    logic [31:0] c, eaddr;
    logic        if_valid, if_valid2;
    logic [31:0] if_pc, if_pc4, if_inst, if_pc2, if_pc4_2, if_inst2;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    fetch_ctrl_if bus();
    fetch_ctrl_if bus2();
    assign bus.imem_rdata  = memf(bus.imem_addr);
    assign bus2.imem_rdata = memf(bus2.imem_addr);
    assign bus2.imem_ready = 1'b1;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_jump(jump), .i_c(c),
        .i_e_raised(e_raised), .i_e_handling_addr(eaddr), .imem(bus),
        .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_pc4(if_pc4), .o_if_inst(if_inst)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .i_stall(1'b0), .i_jump(1'b0), .i_c(32'h0),
        .i_e_raised(1'b0), .i_e_handling_addr(32'h0), .imem(bus2),
        .o_if_valid(if_valid2), .o_if_pc(if_pc2), .o_if_pc4(if_pc4_2), .o_if_inst(if_inst2)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: where the fetcher is, whether a word is parked,
    // whether a redirected request is still in flight, and what decode sees.
    bit          m_started, m_parked, m_inflight, m_valid;
    logic [31:0] m_pc, m_redir_pc, m_park_inst, m_park_pc, m_opc, m_oinst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_parked = 0; m_inflight = 0; m_valid = 0;
        m_pc = 32'h0; m_redir_pc = 32'h0; m_park_inst = 32'h0; m_park_pc = 32'h0;
        m_opc = 32'h0; m_oinst = 32'h0;
    endtask

    task automatic model_step(input bit s, input bit j, input logic [31:0] cc,
                              input bit e, input logic [31:0] ea, input bit rdy);
        bit          redir = j | e;
        logic [31:0] tgt   = j ? cc : ea;
        bit          shown = 0;
        bit          was_valid = m_valid;
        if (!m_started) begin
            m_started = 1;
            if (redir) m_pc = tgt;
        end else if (m_parked) begin
            if (redir) begin
                m_parked = 0; m_pc = tgt;
            end else if (!s) begin
                m_parked = 0; m_opc = m_park_pc; m_oinst = m_park_inst; shown = 1;
            end
        end else if (m_inflight) begin
            if (redir) m_redir_pc = tgt;
            if (rdy) begin
                m_inflight = 0; m_pc = m_redir_pc;
            end
        end else if (redir) begin
            if (rdy) m_pc = tgt;
            else begin
                m_inflight = 1; m_redir_pc = tgt;
            end
        end else if (rdy) begin
            if (!was_valid || !s) begin
                m_opc = m_pc; m_oinst = memf(m_pc); shown = 1;
            end else begin
                m_parked = 1; m_park_pc = m_pc; m_park_inst = memf(m_pc);
            end
            m_pc = m_pc + 32'd4;
        end
        if (redir)      m_valid = 0;
        else if (shown) m_valid = 1;
        else if (!s)    m_valid = 0;
    endtask

    task automatic check_outputs();
        bit exp_req = m_started && !m_parked;
        chk("imem_req", {31'h0, bus.imem_req}, {31'h0, exp_req});
        if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
        chk("if_pc", if_pc, m_opc);
        chk("if_inst", if_inst, m_oinst);
        chk("if_pc4", if_pc4, m_opc + 32'd4);
    endtask

    task automatic cyc(input bit s, input bit j, input logic [31:0] cc,
                       input bit e, input logic [31:0] ea, input bit rdy);
        stall = s; jump = j; c = cc; e_raised = e; eaddr = ea; bus.imem_ready = rdy;
        @(posedge clk);
        model_step(s, j, cc, e, ea, rdy);
        #1;
        check_outputs();
        $display("cyc t=%0t stall=%0d jump=%0d e=%0d rdy=%0d req=%0d addr=%08h valid=%0d pc=%08h inst=%08h",
                 $time, s, j, e, rdy, bus.imem_req, bus.imem_addr, if_valid, if_pc, if_inst);
    endtask

    logic [31:0] old_addr;

    initial begin
        rst_n = 1; rst2_n = 1;
        stall = 0; jump = 0; c = 0; e_raised = 0; eaddr = 0; bus.imem_ready = 0;
        #2 rst_n = 0; rst2_n = 0;
        #1;
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        // Streaming with zero-wait memory
        repeat (6) cyc(0, 0, 0, 0, 0, 1);
        // Decode stall for three cycles, then release
        repeat (3) cyc(1, 0, 0, 0, 0, 1);
        chk("hold_req", {31'h0, bus.imem_req}, 32'h0);
        repeat (4) cyc(0, 0, 0, 0, 0, 1);
        // Simultaneous jump and exception: jump wins
        cyc(0, 1, 32'h100, 1, 32'h80, 1);
        chk("t3_addr", bus.imem_addr, 32'h100);
        chk("t3_valid", {31'h0, if_valid}, 32'h0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // Jump while memory is not ready
        old_addr = bus.imem_addr;
        cyc(0, 1, 32'h200, 0, 0, 0);
        chk("t4_hold1", bus.imem_addr, old_addr);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_hold2", bus.imem_addr, old_addr);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4_target", bus.imem_addr, 32'h200);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        // Exception while a word is parked under stall
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 32'h80, 1);
        chk("t5_valid", {31'h0, if_valid}, 32'h0);
        chk("t5_addr", bus.imem_addr, 32'h80);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom & 32'hFFFF_FFFC,
                ($urandom % 20) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 10) < 7);
        end

        // Wrap-around PC on the second instance
        rst_n = 0;
        rst2_n = 1;
        @(posedge clk); #1;
        chk("w_req", {31'h0, bus2.imem_req}, 32'h1);
        chk("w_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("w_addr1", bus2.imem_addr, 32'h0000_0000);
        chk("w_pc", if_pc2, 32'hFFFF_FFFC);
        chk("w_pc4", if_pc4_2, 32'h0000_0000);
        chk("w_inst", if_inst2, memf(32'hFFFF_FFFC));
        $display("wrap t=%0t addr=%08h pc=%08h pc4=%08h", $time, bus2.imem_addr, if_pc2, if_pc4_2);
        #3 rst2_n = 0;
        #1;
        chk("mid_rst_valid", {31'h0, if_valid2}, 32'h0);
        chk("mid_rst_req", {31'h0, bus2.imem_req}, 32'h0);
        chk("mid_rst_pc", if_pc2, 32'h0);
        chk("mid_rst_inst", if_inst2, 32'h0);
        chk("mid_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
